// File: rtl/m3_run_seq_ctrl.sv
// ============================================================================
// m3_run_seq_ctrl
// Run-sequence controller for the three-phase drive: button conditioning,
// soft start, speed slewing, reversal ramp-down and emergency stop.
// Revision: 1.0
// ============================================================================
`default_nettype none

module m3_run_seq_ctrl #(
  parameter int DB_CYCLES  = 500000,
  parameter int RAMP_TICK  = 50000,
  parameter int FREQ_W     = 16,
  parameter int FREQ_MIN   = 100,
  parameter int FREQ_MAX   = 4000,
  parameter int FREQ_DEF   = 1000,
  parameter int FREQ_STEP  = 100,
  parameter int RAMP_STEP  = 10,
  parameter int DEAD_TICKS = 200
) (
  input  logic              clk50mhz,
  input  logic              nReset,
  input  logic              m3start,
  input  logic              m3forceStop,
  input  logic              m3invRotate,
  input  logic              m3freqINC,
  input  logic              m3freqDEC,
  output logic              drvEn,
  output logic              drvDir,
  output logic [FREQ_W-1:0] freqCmd,
  output logic [FREQ_W-1:0] freqTgt,
  output logic [2:0]        m3state
);

  localparam int DB_W   = $clog2(DB_CYCLES + 1);
  localparam int TICK_W = $clog2(RAMP_TICK + 1);
  localparam int DEAD_W = $clog2(DEAD_TICKS + 1);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_RAMP_UP  = 3'd1;
  localparam logic [2:0] S_RUN      = 3'd2;
  localparam logic [2:0] S_RAMP_DN  = 3'd3;
  localparam logic [2:0] S_OFF_WAIT = 3'd4;

  localparam logic [FREQ_W-1:0] F_MIN   = FREQ_W'(FREQ_MIN);
  localparam logic [FREQ_W-1:0] F_RSTEP = FREQ_W'(RAMP_STEP);
  localparam logic [FREQ_W:0]   X_MIN   = (FREQ_W+1)'(FREQ_MIN);
  localparam logic [FREQ_W:0]   X_MAX   = (FREQ_W+1)'(FREQ_MAX);
  localparam logic [FREQ_W:0]   X_STEP  = (FREQ_W+1)'(FREQ_STEP);

  // Input bit order: 0 start, 1 forceStop, 2 invRotate, 3 freqINC, 4 freqDEC
  logic [4:0] sync1_d, sync1_q, sync2_d, sync2_q;
  logic [3:0] db_in, db_lvl, db_press;

  assign db_in = {sync2_q[4:2], sync2_q[0]};

  for (genvar i = 0; i < 4; i++) begin : g_db
    logic [DB_W-1:0] cnt_d, cnt_q;
    logic            lvl_d, lvl_q, prev_d, prev_q;

    always_comb begin
      cnt_d  = cnt_q;
      lvl_d  = lvl_q;
      prev_d = lvl_q;
      if (db_in[i] == lvl_q) begin
        cnt_d = '0;
      end else if (cnt_q == DB_W'(DB_CYCLES - 1)) begin
        cnt_d = '0;
        lvl_d = db_in[i];
      end else begin
        cnt_d = cnt_q + DB_W'(1);
      end
    end

    always_ff @(posedge clk50mhz or negedge nReset) begin
      if (!nReset) begin
        cnt_q  <= '0;
        lvl_q  <= 1'b0;
        prev_q <= 1'b0;
      end else begin
        cnt_q  <= cnt_d;
        lvl_q  <= lvl_d;
        prev_q <= prev_d;
      end
    end

    assign db_lvl[i]   = lvl_q;
    assign db_press[i] = lvl_q & ~prev_q;
  end

  logic run_req, stop, inv_p, inc_p, dec_p;
  assign run_req = db_lvl[0];
  assign inv_p   = db_press[1];
  assign inc_p   = db_press[2];
  assign dec_p   = db_press[3];
  assign stop    = sync2_q[1];

  logic [2:0]        state_d, state_q;
  logic [FREQ_W-1:0] cmd_d, cmd_q, tgt_d, tgt_q;
  logic              dir_d, dir_q, en_d, en_q, flip_d, flip_q, lock_d, lock_q;
  logic [TICK_W-1:0] tick_cnt_d, tick_cnt_q;
  logic [DEAD_W-1:0] dead_d, dead_q;
  logic              tick;
  logic [FREQ_W:0]   tgt_up, tgt_x;
  logic [FREQ_W-1:0] goal, cmd_ramp;

  assign tick = (tick_cnt_q == TICK_W'(RAMP_TICK - 1));

  always_comb begin
    sync1_d = {m3freqDEC, m3freqINC, m3invRotate, m3forceStop, m3start};
    sync2_d = sync1_q;

    // Target word, computed one bit wider so the clamps cannot wrap
    tgt_x  = {1'b0, tgt_q};
    tgt_up = tgt_x + X_STEP;
    tgt_d  = tgt_q;
    if (inc_p && !dec_p) begin
      tgt_d = (tgt_up > X_MAX) ? X_MAX[FREQ_W-1:0] : tgt_up[FREQ_W-1:0];
    end else if (dec_p && !inc_p) begin
      tgt_d = (tgt_x >= X_MIN + X_STEP) ? tgt_q - X_STEP[FREQ_W-1:0] : F_MIN;
    end

    goal     = (state_q == S_RAMP_DN) ? F_MIN : tgt_q;
    cmd_ramp = cmd_q;
    if (cmd_q < goal) begin
      cmd_ramp = ((goal - cmd_q) > F_RSTEP) ? cmd_q + F_RSTEP : goal;
    end else if (cmd_q > goal) begin
      cmd_ramp = ((cmd_q - goal) > F_RSTEP) ? cmd_q - F_RSTEP : goal;
    end

    state_d    = state_q;
    cmd_d      = cmd_q;
    dir_d      = dir_q;
    flip_d     = flip_q;
    lock_d     = run_req ? lock_q : 1'b0;
    dead_d     = dead_q;
    tick_cnt_d = tick ? '0 : tick_cnt_q + TICK_W'(1);

    if (stop) begin
      state_d    = S_OFF_WAIT;
      cmd_d      = '0;
      lock_d     = 1'b1;
      flip_d     = 1'b0;
      dead_d     = '0;
      tick_cnt_d = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          cmd_d = '0;
          if (inv_p) dir_d = ~dir_q;
          if (run_req && !lock_q) begin
            state_d    = S_RAMP_UP;
            cmd_d      = F_MIN;
            tick_cnt_d = '0;
          end
        end
        S_RAMP_UP, S_RUN: begin
          if (!run_req || inv_p) begin
            state_d    = S_RAMP_DN;
            flip_d     = flip_q | inv_p;
            tick_cnt_d = '0;
          end else begin
            if (tick) cmd_d = cmd_ramp;
            if (state_q == S_RAMP_UP && cmd_q == tgt_q) state_d = S_RUN;
          end
        end
        S_RAMP_DN: begin
          if (cmd_q == F_MIN) begin
            state_d    = S_OFF_WAIT;
            cmd_d      = '0;
            dead_d     = '0;
            tick_cnt_d = '0;
          end else if (tick) begin
            cmd_d = cmd_ramp;
          end
        end
        S_OFF_WAIT: begin
          cmd_d = '0;
          if (tick) begin
            if (dead_q == DEAD_W'(DEAD_TICKS - 1)) begin
              dead_d = '0;
              if (flip_q) begin
                dir_d  = ~dir_q;
                flip_d = 1'b0;
              end
              if (run_req && !lock_q) begin
                state_d    = S_RAMP_UP;
                cmd_d      = F_MIN;
                tick_cnt_d = '0;
              end else begin
                state_d = S_IDLE;
              end
            end else begin
              dead_d = dead_q + DEAD_W'(1);
            end
          end
        end
        default: begin
          state_d = S_IDLE;
          cmd_d   = '0;
        end
      endcase
    end

    en_d = (state_d == S_RAMP_UP) || (state_d == S_RUN) || (state_d == S_RAMP_DN);
  end

  always_ff @(posedge clk50mhz or negedge nReset) begin
    if (!nReset) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      state_q    <= S_IDLE;
      cmd_q      <= '0;
      tgt_q      <= FREQ_W'(FREQ_DEF);
      dir_q      <= 1'b0;
      en_q       <= 1'b0;
      flip_q     <= 1'b0;
      lock_q     <= 1'b0;
      dead_q     <= '0;
      tick_cnt_q <= '0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      tgt_q      <= tgt_d;
      dir_q      <= dir_d;
      en_q       <= en_d;
      flip_q     <= flip_d;
      lock_q     <= lock_d;
      dead_q     <= dead_d;
      tick_cnt_q <= tick_cnt_d;
    end
  end

  assign drvEn   = en_q;
  assign drvDir  = dir_q;
  assign freqCmd = cmd_q;
  assign freqTgt = tgt_q;
  assign m3state = state_q;

endmodule

`default_nettype wire

// File: tb/tb_m3_run_seq_ctrl.sv
// ============================================================================
// tb_m3_run_seq_ctrl
// Directed scenarios plus randomized target presses against a clamp model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_m3_run_seq_ctrl;

  logic        clk = 1'b0;
  logic        nReset = 1'b0;
  logic        m3start = 1'b0, m3forceStop = 1'b0, m3invRotate = 1'b0;
  logic        m3freqINC = 1'b0, m3freqDEC = 1'b0;
  logic        drvEn, drvDir;
  logic [15:0] freqCmd, freqTgt;
  logic [2:0]  m3state;

  int checks = 0;
  int failures = 0;
  int model_tgt = 200;

  m3_run_seq_ctrl #(
    .DB_CYCLES(4), .RAMP_TICK(8), .FREQ_W(16), .FREQ_MIN(100), .FREQ_MAX(400),
    .FREQ_DEF(200), .FREQ_STEP(50), .RAMP_STEP(25), .DEAD_TICKS(2)
  ) dut (
    .clk50mhz(clk), .nReset(nReset), .m3start(m3start), .m3forceStop(m3forceStop),
    .m3invRotate(m3invRotate), .m3freqINC(m3freqINC), .m3freqDEC(m3freqDEC),
    .drvEn(drvEn), .drvDir(drvDir), .freqCmd(freqCmd), .freqTgt(freqTgt),
    .m3state(m3state)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // which: 0 invRotate, 1 INC, 2 DEC, 3 INC+DEC together
  task automatic press(input int which);
    m3invRotate = (which == 0);
    m3freqINC   = (which == 1) || (which == 3);
    m3freqDEC   = (which == 2) || (which == 3);
    cyc(8);
    m3invRotate = 1'b0;
    m3freqINC   = 1'b0;
    m3freqDEC   = 1'b0;
    cyc(8);
  endtask

  task automatic wait_state(input logic [2:0] exp, input int max_cyc, input string tag);
    int n = 0;
    while (m3state !== exp && n < max_cyc) begin
      cyc(1);
      n++;
    end
    chk(tag, 32'(m3state), 32'(exp));
  endtask

  task automatic wait_settle(input int max_cyc, input string tag);
    int n = 0;
    while (!(m3state === 3'd2 && freqCmd === 16'(model_tgt)) && n < max_cyc) begin
      cyc(1);
      n++;
    end
    chk(tag, 32'(freqCmd), 32'(model_tgt));
  endtask

  initial begin
    int prev_cmd;
    int cnt;
    int r;
    int n;

    // Reset state
    cyc(3);
    chk("rst_en", 32'(drvEn), 0);
    chk("rst_dir", 32'(drvDir), 0);
    chk("rst_cmd", 32'(freqCmd), 0);
    chk("rst_tgt", 32'(freqTgt), 200);
    chk("rst_state", 32'(m3state), 0);
    nReset = 1'b1;
    cyc(2);

    // 1. Start: drvEn on the 7th edge, then four ticks of 25
    m3start = 1'b1;
    cyc(6);
    chk("start_en_early", 32'(drvEn), 0);
    cyc(1);
    chk("start_en", 32'(drvEn), 1);
    chk("start_cmd", 32'(freqCmd), 100);
    chk("start_state", 32'(m3state), 1);
    cyc(31);
    chk("ramp_3ticks", 32'(freqCmd), 175);
    cyc(1);
    chk("ramp_4ticks", 32'(freqCmd), 200);
    cyc(1);
    chk("run_state", 32'(m3state), 2);

    // 2. Debounce and saturation
    m3freqINC = 1'b1;
    cyc(3);
    m3freqINC = 1'b0;
    cyc(12);
    chk("inc_glitch", 32'(freqTgt), 200);
    m3freqINC = 1'b1;
    cyc(10);
    m3freqINC = 1'b0;
    chk("inc_press", 32'(freqTgt), 250);
    cyc(8);
    model_tgt = 250;
    wait_settle(40, "inc_cmd_250");
    repeat (5) press(1);
    chk("inc_sat", 32'(freqTgt), 400);
    press(3);
    chk("inc_dec_same", 32'(freqTgt), 400);
    press(2);
    chk("dec_press", 32'(freqTgt), 350);
    model_tgt = 350;

    // Randomized presses against the clamp model
    for (int i = 0; i < 12; i++) begin
      r = $urandom_range(0, 3);
      case (r)
        0: begin
          press(1);
          model_tgt = (model_tgt + 50 > 400) ? 400 : model_tgt + 50;
        end
        1: begin
          press(2);
          model_tgt = (model_tgt - 50 < 100) ? 100 : model_tgt - 50;
        end
        2: press(3);
        default: begin
          n = $urandom_range(1, 3);
          if ($urandom_range(0, 1) == 1) m3freqINC = 1'b1;
          else m3freqDEC = 1'b1;
          cyc(n);
          m3freqINC = 1'b0;
          m3freqDEC = 1'b0;
          cyc(12);
        end
      endcase
      chk("rand_tgt", 32'(freqTgt), 32'(model_tgt));
    end
    wait_settle(300, "rand_settle");
    while (model_tgt > 200) begin
      press(2);
      model_tgt -= 50;
    end
    while (model_tgt < 200) begin
      press(1);
      model_tgt += 50;
    end
    chk("restore_tgt", 32'(freqTgt), 200);
    wait_settle(200, "restore_cmd");

    // 3. Reversal from RUN
    m3invRotate = 1'b1;
    wait_state(3'd3, 12, "rev_rampdn");
    m3invRotate = 1'b0;
    cyc(8);
    press(0);
    n = 0;
    prev_cmd = freqCmd;
    while (m3state !== 3'd4 && n < 100) begin
      prev_cmd = freqCmd;
      cyc(1);
      n++;
    end
    chk("rev_offwait", 32'(m3state), 4);
    chk("rev_cmd_min", 32'(prev_cmd), 100);
    chk("rev_off_en", 32'(drvEn), 0);
    chk("rev_off_cmd", 32'(freqCmd), 0);
    cnt = 0;
    while (m3state === 3'd4 && cnt < 40) begin
      cnt++;
      cyc(1);
    end
    chk("rev_dead_len", 32'(cnt), 16);
    chk("rev_restart_state", 32'(m3state), 1);
    chk("rev_dir", 32'(drvDir), 1);
    chk("rev_restart_cmd", 32'(freqCmd), 100);
    wait_settle(100, "rev_settle");
    chk("rev_dir_once", 32'(drvDir), 1);

    // 4. forceStop during RAMP_UP
    m3start = 1'b0;
    wait_state(3'd0, 200, "s4_idle");
    m3start = 1'b1;
    wait_state(3'd1, 12, "s4_rampup");
    m3forceStop = 1'b1;
    cyc(2);
    chk("stop_lat2", 32'(drvEn), 1);
    cyc(1);
    chk("stop_en", 32'(drvEn), 0);
    chk("stop_cmd", 32'(freqCmd), 0);
    chk("stop_state", 32'(m3state), 4);
    cyc(30);
    chk("stop_hold", 32'(m3state), 4);
    m3forceStop = 1'b0;
    wait_state(3'd0, 40, "stop_idle");
    cyc(30);
    chk("stop_lock", 32'(m3state), 0);
    chk("stop_lock_en", 32'(drvEn), 0);
    m3start = 1'b0;
    cyc(10);
    m3start = 1'b1;
    cyc(7);
    chk("stop_restart", 32'(m3state), 1);

    // 5. Reverse in IDLE
    m3start = 1'b0;
    wait_state(3'd0, 200, "s5_idle");
    press(0);
    chk("idle_dir0", 32'(drvDir), 0);
    chk("idle_en", 32'(drvEn), 0);
    chk("idle_state", 32'(m3state), 0);
    press(0);
    chk("idle_dir1", 32'(drvDir), 1);

    // 6. Asynchronous reset in RUN
    m3start = 1'b1;
    wait_state(3'd2, 60, "s6_run");
    press(1);
    chk("s6_tgt", 32'(freqTgt), 250);
    #3;
    nReset = 1'b0;
    #1;
    chk("arst_en", 32'(drvEn), 0);
    chk("arst_dir", 32'(drvDir), 0);
    chk("arst_cmd", 32'(freqCmd), 0);
    chk("arst_tgt", 32'(freqTgt), 200);
    chk("arst_state", 32'(m3state), 0);
    #1;
    nReset = 1'b1;
    cyc(6);
    chk("arst_en_early", 32'(drvEn), 0);
    cyc(1);
    chk("arst_restart_en", 32'(drvEn), 1);
    chk("arst_restart_cmd", 32'(freqCmd), 100);
    chk("arst_restart_state", 32'(m3state), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
